// File: rtl/sram_wrapper_banked.sv
// DATA_WIDTH x DEPTH 1W/1R memory tiled from 32x256 macros, with byte masking,
// registered read-valid, output hold and same-address write-to-read forwarding.

module sram_32x256_1w1r (
  input  logic        clk0,
  input  logic        csb0,
  input  logic        web0,
  input  logic [3:0]  wmask0,
  input  logic [7:0]  addr0,
  input  logic [31:0] din0,
  input  logic        clk1,
  input  logic        csb1,
  input  logic [7:0]  addr1,
  output logic [31:0] dout1
);

  logic [31:0] mem [256];

  always_ff @(posedge clk0) begin
    if (!csb0 && !web0) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wmask0[b]) mem[addr0][8*b +: 8] <= din0[8*b +: 8];
      end
    end
  end

  // Read-before-write on a same-address collision; the wrapper forwards.
  always_ff @(posedge clk1) begin
    if (!csb1) dout1 <= mem[addr1];
  end

endmodule

module sram_wrapper_banked #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned NUM_WMASKS = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] wadr,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic [NUM_WMASKS-1:0] wmask,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] radr,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  rvalid,
  output logic                  collision
);

  localparam int unsigned COLS   = DATA_WIDTH / 32;
  localparam int unsigned ROWS   = DEPTH / 256;
  localparam int unsigned BANK_W = (ADDR_WIDTH > 8) ? ADDR_WIDTH - 8 : 1;

  logic [BANK_W-1:0] wbank, rbank;
  logic              wok, rok;
  logic              wr_en, rd_en, hit;
  logic [ROWS-1:0]   wsel, rsel;
  logic [31:0]       rdata [ROWS][COLS];

  logic                  re_q, hit_q, rok_q;
  logic [BANK_W-1:0]     bank_q;
  logic [NUM_WMASKS-1:0] wmask_q;
  logic [DATA_WIDTH-1:0] d_q;
  logic [DATA_WIDTH-1:0] mem_word, fwd_word;

  if (ADDR_WIDTH > 8) begin : g_bank_bits
    assign wbank = wadr[ADDR_WIDTH-1:8];
    assign rbank = radr[ADDR_WIDTH-1:8];
  end else begin : g_single_bank
    assign wbank = '0;
    assign rbank = '0;
  end

  // Bank indices beyond ROWS only exist when DEPTH/256 is not a power of two.
  assign wok   = (32'(wbank) < ROWS);
  assign rok   = (32'(rbank) < ROWS);
  assign wr_en = we & rst_n & wok;
  assign rd_en = re & rst_n;
  assign hit   = re & we & wok & (radr == wadr) & (|wmask);

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign wsel[r] = wr_en & (wbank == BANK_W'(r));
    assign rsel[r] = rd_en & (rbank == BANK_W'(r));
    for (genvar c = 0; c < COLS; c++) begin : g_col
      sram_32x256_1w1r u_macro (
        .clk0   (clk),
        .csb0   (~wsel[r]),
        .web0   (~wsel[r]),
        .wmask0 (wmask[4*c +: 4]),
        .addr0  (wadr[7:0]),
        .din0   (d[32*c +: 32]),
        .clk1   (clk),
        .csb1   (~rsel[r]),
        .addr1  (radr[7:0]),
        .dout1  (rdata[r][c])
      );
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_q    <= 1'b0;
      hit_q   <= 1'b0;
      rok_q   <= 1'b0;
      bank_q  <= '0;
      wmask_q <= '0;
      d_q     <= '0;
    end else begin
      re_q  <= re;
      hit_q <= hit;
      if (re) begin
        bank_q <= rbank;
        rok_q  <= rok;
      end
      if (hit) begin
        wmask_q <= wmask;
        d_q     <= d;
      end
    end
  end

  always_comb begin
    mem_word = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (rok_q && (bank_q == BANK_W'(r))) begin
        for (int unsigned c = 0; c < COLS; c++) mem_word[32*c +: 32] = rdata[r][c];
      end
    end
  end

  always_comb begin
    fwd_word = mem_word;
    if (hit_q) begin
      for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
        if (wmask_q[i]) fwd_word[8*i +: 8] = d_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q         <= '0;
      rvalid    <= 1'b0;
      collision <= 1'b0;
    end else begin
      rvalid    <= re_q;
      collision <= re_q & hit_q;
      if (re_q) q <= fwd_word;
    end
  end

endmodule

// File: tb/tb_sram_wrapper_banked.sv
// Directed bench for sram_wrapper_banked at 64 x 1024 (4 banks, 2 macro columns).

module tb_sram_wrapper_banked;

  localparam int unsigned DW = 64;
  localparam int unsigned DP = 1024;
  localparam int unsigned AW = 10;
  localparam int unsigned MW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] wadr, radr;
  logic [DW-1:0] d;
  logic [MW-1:0] wmask;
  logic          we, re;
  logic [DW-1:0] q;
  logic          rvalid, collision;

  int unsigned passed = 0;
  int unsigned total  = 0;

  sram_wrapper_banked #(
    .DATA_WIDTH (DW),
    .DEPTH      (DP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wadr      (wadr),
    .d         (d),
    .wmask     (wmask),
    .we        (we),
    .radr      (radr),
    .re        (re),
    .q         (q),
    .rvalid    (rvalid),
    .collision (collision)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] v, input logic [MW-1:0] m);
    we = 1'b1; wadr = a; d = v; wmask = m;
    tick();
    we = 1'b0; wmask = '0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    re = 1'b1; radr = a;
    tick();
    re = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; re = 1'b0;
    wadr = '0; radr = '0; d = '0; wmask = '0;

    // Reset held for 3 cycles
    repeat (3) tick();
    chk("rst_q", q, 64'h0);
    chk("rst_rvalid", {63'd0, rvalid}, 64'h0);
    chk("rst_collision", {63'd0, collision}, 64'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_rvalid", {63'd0, rvalid}, 64'h0);
    end

    // Full-width write to top of bank 3, read back
    wr(10'h3FF, 64'hDEADBEEF_01234567, 8'hFF);
    rd(10'h3FF);
    chk("full_latency_rvalid", {63'd0, rvalid}, 64'h0);
    tick();
    chk("full_rvalid", {63'd0, rvalid}, 64'h1);
    chk("full_q", q, 64'hDEADBEEF_01234567);
    tick();
    chk("full_rvalid_drop", {63'd0, rvalid}, 64'h0);
    chk("full_q_hold", q, 64'hDEADBEEF_01234567);

    // Zero-mask write leaves memory untouched
    wr(10'h3FF, 64'h0, 8'h00);
    rd(10'h3FF);
    tick();
    chk("zero_mask_q", q, 64'hDEADBEEF_01234567);

    // Byte mask on address 5
    wr(10'd5, 64'h0, 8'hFF);
    wr(10'd5, 64'h00000000_FFFFFFFF, 8'h0F);
    wr(10'd5, 64'h0, 8'h05);
    rd(10'd5);
    tick();
    chk("bytemask_q", q, 64'h00000000_FF00FF00);

    // Collision forwarding on address 9
    wr(10'd9, 64'h00000000_11223344, 8'hFF);
    we = 1'b1; wadr = 10'd9; d = 64'h00000000_AABBCCDD; wmask = 8'h03;
    re = 1'b1; radr = 10'd9;
    tick();
    we = 1'b0; re = 1'b0; wmask = '0;
    chk("coll_early", {63'd0, collision}, 64'h0);
    tick();
    chk("coll_q", q, 64'h00000000_1122CCDD);
    chk("coll_pulse", {63'd0, collision}, 64'h1);
    chk("coll_rvalid", {63'd0, rvalid}, 64'h1);
    tick();
    chk("coll_pulse_end", {63'd0, collision}, 64'h0);
    rd(10'd9);
    tick();
    chk("coll_reread_q", q, 64'h00000000_1122CCDD);
    chk("coll_reread_flag", {63'd0, collision}, 64'h0);

    // Same bank, different addresses, concurrent read and write
    we = 1'b1; wadr = 10'h3FE; d = 64'h55; wmask = 8'hFF;
    re = 1'b1; radr = 10'h3FF;
    tick();
    we = 1'b0; re = 1'b0; wmask = '0;
    tick();
    chk("samebank_q", q, 64'hDEADBEEF_01234567);
    chk("samebank_coll", {63'd0, collision}, 64'h0);
    rd(10'h3FE);
    tick();
    chk("samebank_wr_q", q, 64'h55);

    // Bank crossing with back-to-back reads then hold
    wr(10'h0FF, 64'hA, 8'hFF);
    wr(10'h100, 64'hB, 8'hFF);
    re = 1'b1; radr = 10'h0FF;
    tick();
    radr = 10'h100;
    tick();
    re = 1'b0;
    chk("cross_q0", q, 64'hA);
    chk("cross_rv0", {63'd0, rvalid}, 64'h1);
    tick();
    chk("cross_q1", q, 64'hB);
    chk("cross_rv1", {63'd0, rvalid}, 64'h1);
    tick();
    chk("hold_q", q, 64'hB);
    chk("hold_rvalid", {63'd0, rvalid}, 64'h0);
    tick();
    chk("hold_q2", q, 64'hB);

    // Reset asserted while a read is in flight
    re = 1'b1; radr = 10'h3FF;
    tick();
    re = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_q", q, 64'h0);
    chk("midrst_rvalid", {63'd0, rvalid}, 64'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("postrst_rvalid", {63'd0, rvalid}, 64'h0);
      chk("postrst_q", q, 64'h0);
    end

    // Memory survives reset
    rd(10'h100);
    tick();
    chk("post_reset_mem", q, 64'hB);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
